// File: rtl/i2c_byte_master.sv
// Purpose : byte-level I2C master; executes START / WRITE / READ / STOP commands on open-drain lines.
// Latency : rsp_valid_o is seen 4*QTR_DIV*N + 1 cycles after accept (N = 1 START/STOP, 9 WRITE/READ) plus SCL stretch time.
// Backpr. : cmd_ready_o is high only while idle and not pulsing rsp_valid_o; one command in flight at a time.
//
// Ports: clk_i/rst_i (async active-low) | cmd_valid_i, cmd_ready_o, cmd_i, wdata_i, rd_ack_i (command side)
//        rsp_valid_o, rdata_o, ack_o, busy_o (completion side) | sda_bi, scl_bi (open-drain I2C lines)
module i2c_byte_master #(
    parameter int QTR_DIV = 125
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] wdata_i,
    input  logic       rd_ack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rdata_o,
    output logic       ack_o,
    output logic       busy_o,
    inout  tri         sda_bi,
    inout  tri         scl_bi
);

    localparam int CW = $clog2(QTR_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(QTR_DIV - 1);
    // First count value at which the synchronized SCL reflects our own release.
    localparam logic [CW-1:0] CNT_SYNC = CW'((QTR_DIV > 2) ? 2 : QTR_DIV - 1);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_XFER,
        ST_STOP
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    qtr, qtr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_idx, bit_nxt;
    logic [7:0]    sreg, sreg_nxt;
    logic          is_read, is_read_nxt;
    logic          rd_ack_q, rd_ack_nxt;
    logic          sda_oe, sda_oe_nxt;   // 1 = pull line low
    logic          scl_oe, scl_oe_nxt;
    logic [7:0]    rdata_nxt;
    logic          ack_nxt;
    logic          rsp_nxt;
    logic          ready_en;
    logic [1:0]    sda_sync, scl_sync;
    logic          sda_s, scl_s;
    logic          accept, tick, stretch_hold;

    assign sda_bi = sda_oe ? 1'b0 : 1'bz;
    assign scl_bi = scl_oe ? 1'b0 : 1'bz;

    assign sda_s = sda_sync[1];
    assign scl_s = scl_sync[1];

    assign cmd_ready_o = ready_en && (state == ST_IDLE) && !rsp_valid_o;
    assign busy_o      = (state != ST_IDLE) || rsp_valid_o;
    assign accept      = cmd_valid_i && cmd_ready_o;

    // Once SCL has been released in q1, a slave holding it low freezes the
    // quarter; the remaining q1 time runs only after SCL is seen high, so the
    // high phase keeps its full length.
    assign stretch_hold = ((state == ST_XFER) || (state == ST_STOP)) && (qtr == 2'd1)
                          && (cnt >= CNT_SYNC) && !scl_s;
    assign tick = (state != ST_IDLE) && (cnt == CNT_LAST) && !stretch_hold;

    always_comb begin
        state_nxt   = state;
        qtr_nxt     = qtr;
        cnt_nxt     = cnt;
        bit_nxt     = bit_idx;
        sreg_nxt    = sreg;
        is_read_nxt = is_read;
        rd_ack_nxt  = rd_ack_q;
        sda_oe_nxt  = sda_oe;
        scl_oe_nxt  = scl_oe;
        rdata_nxt   = rdata_o;
        ack_nxt     = ack_o;
        rsp_nxt     = 1'b0;

        if (state == ST_IDLE || cnt == CNT_LAST) begin
            cnt_nxt = '0;
        end else if (!stretch_hold) begin
            cnt_nxt = cnt + CW'(1);
        end
        if (stretch_hold) begin
            cnt_nxt = cnt;
        end

        // Line actions of a quarter are applied on the edge that enters it.
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    qtr_nxt     = 2'd0;
                    bit_nxt     = 4'd0;
                    is_read_nxt = (cmd_i == CMD_READ);
                    rd_ack_nxt  = rd_ack_i;
                    sreg_nxt    = (cmd_i == CMD_READ) ? 8'h00 : wdata_i;
                    case (cmd_i)
                        CMD_START: begin
                            state_nxt  = ST_START;
                            sda_oe_nxt = 1'b0;
                            scl_oe_nxt = 1'b0;
                        end
                        CMD_WRITE, CMD_READ: begin
                            state_nxt  = ST_XFER;
                            scl_oe_nxt = 1'b1;
                            sda_oe_nxt = (cmd_i == CMD_WRITE) && !wdata_i[7];
                        end
                        default: begin
                            state_nxt  = ST_STOP;
                            sda_oe_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ST_START: begin
                if (tick) begin
                    qtr_nxt = qtr + 2'd1;
                    case (qtr)
                        2'd0:    sda_oe_nxt = 1'b1;
                        2'd1:    scl_oe_nxt = 1'b1;
                        2'd3: begin
                            state_nxt = ST_IDLE;
                            rsp_nxt   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_XFER: begin
                if (tick) begin
                    qtr_nxt = qtr + 2'd1;
                    case (qtr)
                        2'd0: scl_oe_nxt = 1'b0;
                        2'd1: begin
                            if (bit_idx < 4'd8) begin
                                sreg_nxt = {sreg[6:0], sda_s};
                            end else if (is_read) begin
                                rdata_nxt = sreg;
                            end else begin
                                ack_nxt = !sda_s;
                            end
                        end
                        2'd2: scl_oe_nxt = 1'b1;
                        default: begin
                            if (bit_idx == 4'd8) begin
                                state_nxt = ST_IDLE;
                                rsp_nxt   = 1'b1;
                            end else begin
                                bit_nxt = bit_idx + 4'd1;
                                // sreg[7] already holds the next write bit after the q2 shift.
                                if (bit_idx == 4'd7) begin
                                    sda_oe_nxt = is_read && rd_ack_q;
                                end else begin
                                    sda_oe_nxt = !is_read && !sreg[7];
                                end
                            end
                        end
                    endcase
                end
            end
            default: begin
                if (tick) begin
                    qtr_nxt = qtr + 2'd1;
                    case (qtr)
                        2'd0:    scl_oe_nxt = 1'b0;
                        2'd1:    sda_oe_nxt = 1'b0;
                        2'd3: begin
                            state_nxt = ST_IDLE;
                            rsp_nxt   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= ST_IDLE;
            qtr         <= 2'd0;
            cnt         <= '0;
            bit_idx     <= 4'd0;
            sreg        <= 8'h00;
            is_read     <= 1'b0;
            rd_ack_q    <= 1'b0;
            sda_oe      <= 1'b0;
            scl_oe      <= 1'b0;
            rdata_o     <= 8'h00;
            ack_o       <= 1'b0;
            rsp_valid_o <= 1'b0;
            ready_en    <= 1'b0;
            sda_sync    <= 2'b11;
            scl_sync    <= 2'b11;
        end else begin
            state       <= state_nxt;
            qtr         <= qtr_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_nxt;
            sreg        <= sreg_nxt;
            is_read     <= is_read_nxt;
            rd_ack_q    <= rd_ack_nxt;
            sda_oe      <= sda_oe_nxt;
            scl_oe      <= scl_oe_nxt;
            rdata_o     <= rdata_nxt;
            ack_o       <= ack_nxt;
            rsp_valid_o <= rsp_nxt;
            ready_en    <= 1'b1;
            sda_sync    <= {sda_sync[0], sda_bi};
            scl_sync    <= {scl_sync[0], scl_bi};
        end
    end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Purpose : directed + randomized bench for i2c_byte_master with a bus-level slave model.
// Latency : counted as rising edges from the accept edge (edge 0) to the first edge that samples rsp_valid_o high.
// Backpr. : commands are held on cmd_valid_i until cmd_ready_o is seen.
module tb_i2c_byte_master;

    localparam int Q     = 4;
    localparam int LIMIT = 3000;
    localparam logic [1:0] C_START = 2'b00, C_WRITE = 2'b01, C_READ = 2'b10, C_STOP = 2'b11;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i, cmd_ready_o, rd_ack_i, rsp_valid_o, ack_o, busy_o;
    logic [1:0] cmd_i;
    logic [7:0] wdata_i, rdata_o;
    tri         sda_bi, scl_bi;

    // Slave side of the wired-AND bus.
    logic       slv_sda = 1'b0, slv_scl = 1'b0;
    int         slv_mode = 0;            // 0 silent, 1 ACKing writer target, 2 read source
    logic [7:0] slv_byte = 8'h00;
    bit         stretch_en = 1'b0;

    pullup (sda_bi);
    pullup (scl_bi);
    assign sda_bi = slv_sda ? 1'b0 : 1'bz;
    assign scl_bi = slv_scl ? 1'b0 : 1'bz;

    i2c_byte_master #(.QTR_DIV(Q)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_i(cmd_i), .wdata_i(wdata_i), .rd_ack_i(rd_ack_i), .rsp_valid_o(rsp_valid_o),
        .rdata_o(rdata_o), .ack_o(ack_o), .busy_o(busy_o), .sda_bi(sda_bi), .scl_bi(scl_bi)
    );

    always #5 clk_i = ~clk_i;

    int   n_assert = 0, n_fail = 0;
    int   bitn = 0, start_cnt = 0, stop_cnt = 0, rsp_cnt = 0;
    logic rise_q[$];
    time  t_rise = 0, hi3 = 0;

    function automatic logic slv_bit(input int n);
        case (slv_mode)
            1:       return (n == 8);
            2:       return (n < 8) ? !slv_byte[3'(7 - n)] : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge scl_bi) begin
        rise_q.push_back(sda_bi);
        bitn++;
        t_rise = $time;
    end

    always @(negedge scl_bi) begin
        if (bitn == 3) hi3 = $time - t_rise;
        slv_sda = slv_bit(bitn);
    end

    // Hold SCL low from the fall ending bit 2 until 20 cycles after the master releases it in bit 3.
    always @(negedge scl_bi) begin
        if (stretch_en && bitn == 2) begin
            stretch_en = 1'b0;
            slv_scl = 1'b1;
            repeat (2 * Q + 20) @(posedge clk_i);
            #1 slv_scl = 1'b0;
        end
    end

    always @(negedge sda_bi) if (scl_bi === 1'b1) start_cnt++;
    always @(posedge sda_bi) if (scl_bi === 1'b1) stop_cnt++;
    always @(posedge clk_i) if (rsp_valid_o) rsp_cnt++;

    // Reference model: last READ byte and last WRITE acknowledge.
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge following the response pulse.
    task automatic do_cmd(input string tag, input logic [1:0] c, input logic [7:0] wd,
                          input logic ra, output int lat);
        int w, k;
        cmd_valid_i = 1'b1; cmd_i = c; wdata_i = wd; rd_ack_i = ra;
        w = 0;
        while (!cmd_ready_o && w < 100) begin @(posedge clk_i); #1; w++; end
        check({tag, "_ready_wait"}, 32'(w < 100), 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; cmd_i = 2'b00; wdata_i = 8'h00; rd_ack_i = 1'b0;
        check({tag, "_busy_acc"}, {30'd0, busy_o, cmd_ready_o}, 32'b10);
        k = 0;
        while (!rsp_valid_o && k < LIMIT) begin @(posedge clk_i); #1; k++; end
        check({tag, "_rsp_seen"}, 32'(k < LIMIT), 1);
        lat = k + 1;
        check({tag, "_busy_rsp"}, {30'd0, busy_o, cmd_ready_o}, 32'b10);
        @(posedge clk_i); #1;
        check({tag, "_after_rsp"}, {29'd0, rsp_valid_o, busy_o, cmd_ready_o}, 32'b001);
    endtask

    task automatic run_xfer(input string tag, input bit rd, input logic [7:0] b,
                            input bit sack, input bit rdack, input bit stretch);
        int lat;
        logic [8:0] obs_bits, exp_bits;
        bitn = 0;
        rise_q.delete();
        slv_byte = b;
        slv_mode = rd ? 2 : (sack ? 1 : 0);
        slv_sda = slv_bit(0);
        stretch_en = stretch;
        do_cmd(tag, rd ? C_READ : C_WRITE, rd ? 8'($urandom) : b, rdack, lat);
        if (rd) exp_rdata = b; else exp_ack = sack;
        exp_bits = {b, rd ? !rdack : !sack};
        obs_bits = '0;
        for (int i = 0; i < rise_q.size() && i < 9; i++) obs_bits[8 - i] = rise_q[i];
        if (stretch) check({tag, "_lat_range"}, 32'(lat >= 4 * Q * 9 + 21 && lat <= 4 * Q * 9 + 23), 1);
        else         check({tag, "_lat"}, 32'(lat), 4 * Q * 9 + 1);
        check({tag, "_nrise"}, 32'(rise_q.size()), 9);
        check({tag, "_bits"}, 32'(obs_bits), 32'(exp_bits));
        check({tag, "_rdata"}, 32'(rdata_o), 32'(exp_rdata));
        check({tag, "_ack"}, 32'(ack_o), 32'(exp_ack));
        slv_mode = 0;
        slv_sda = 1'b0;
    endtask

    initial begin
        int lat, k, acc, s0, rc0;
        logic [7:0] b;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_i = 2'b00; wdata_i = 8'h00; rd_ack_i = 1'b0;
        #2 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", {19'd0, cmd_ready_o, busy_o, rsp_valid_o, ack_o, rdata_o}, 32'h0);
        check("reset_lines", {30'd0, sda_bi, scl_bi}, 32'b11);
        #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("ready_after_reset", 32'(cmd_ready_o), 1);

        s0 = start_cnt;
        do_cmd("start", C_START, 8'h00, 1'b0, lat);
        check("start_lat", 32'(lat), 4 * Q + 1);
        check("start_cond", 32'(start_cnt - s0), 1);
        check("start_lines", {30'd0, sda_bi, scl_bi}, 32'b00);

        run_xfer("wr_a5", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
        check("wr_a5_scl_high", 32'((hi3 + 5) / 10), 2 * Q);
        run_xfer("wr_50_noack", 1'b0, 8'h50, 1'b0, 1'b1, 1'b0);
        run_xfer("rd_3c", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            run_xfer($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), b,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        run_xfer("wr_stretch", 1'b0, 8'($urandom), 1'b1, 1'b0, 1'b1);
        check("stretch_scl_high", 32'((hi3 + 5) / 10), 2 * Q);

        // STOP with cmd_valid_i held high across two commands.
        s0 = stop_cnt;
        cmd_valid_i = 1'b1; cmd_i = C_STOP;
        @(posedge clk_i); #1;
        acc = 0; k = 0;
        while (!rsp_valid_o && k < LIMIT) begin
            if (cmd_ready_o) acc++;
            @(posedge clk_i); #1; k++;
        end
        check("stop_lat", 32'(k + 1), 4 * Q + 1);
        check("stop_no_reaccept", 32'(acc), 0);
        check("stop_ready_rsp", 32'(cmd_ready_o), 0);
        check("stop_cond", 32'(stop_cnt - s0), 1);
        check("stop_lines", {30'd0, sda_bi, scl_bi}, 32'b11);
        @(posedge clk_i); #1;
        check("stop_ready_next", {30'd0, cmd_ready_o, rsp_valid_o}, 32'b10);
        @(posedge clk_i); #1;
        check("stop2_accepted", {30'd0, busy_o, cmd_ready_o}, 32'b10);
        cmd_valid_i = 1'b0;
        k = 0;
        while (!rsp_valid_o && k < LIMIT) begin @(posedge clk_i); #1; k++; end
        check("stop2_rsp", 32'(k < LIMIT), 1);
        @(posedge clk_i); #1;

        // Reset in the middle of WRITE bit 4 (byte 0x00 keeps both lines low there).
        do_cmd("start2", C_START, 8'h00, 1'b0, lat);
        bitn = 0;
        rise_q.delete();
        cmd_valid_i = 1'b1; cmd_i = C_WRITE; wdata_i = 8'h00;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        rc0 = rsp_cnt;
        repeat (49) @(posedge clk_i);
        #2;
        check("bit4_lines_low", {29'd0, sda_bi, scl_bi, 1'b0}, 32'b000);
        check("bit4_rises", 32'(bitn), 3);
        rst_i = 1'b0;
        #1;
        check("rst_lines_released", {30'd0, sda_bi, scl_bi}, 32'b11);
        check("rst_outputs", {19'd0, cmd_ready_o, busy_o, rsp_valid_o, ack_o, rdata_o}, 32'h0);
        exp_ack = 1'b0; exp_rdata = 8'h00;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_ready_one_edge", 32'(cmd_ready_o), 1);
        check("rst_no_rsp", 32'(rsp_cnt - rc0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 QTR_DIV, default 125, clk_i cycles per quarter SCL bit period; legal range >= 2.
REQ-002 clk_i  input  1  system clock; all logic on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-006 cmd_i  input  2  00 START, 01 WRITE, 10 READ, 11 STOP.
REQ-007 wdata_i  input  8  WRITE byte, MSB first.
REQ-008 rd_ack_i  input  1  READ 9th bit: 1 = ACK (SDA low), 0 = NACK.
REQ-009 rsp_valid_o  output  1  one-cycle completion pulse.
REQ-010 rdata_o  output  8  last READ byte.
REQ-011 ack_o  output  1  last WRITE: 1 = slave ACK.
REQ-012 busy_o  output  1  high while a command executes.
REQ-013 sda_bi  inout  tri  I2C data, open-drain.
REQ-014 scl_bi  inout  tri  I2C clock, open-drain.

Function
REQ-015 Lines SHALL be driven only 0 or 'z, never 1; line inputs pass a 2-flop synchronizer before use.
REQ-016 Accept on rising edge with cmd_valid_i & cmd_ready_o; cmd_i, wdata_i, rd_ack_i captured then; cmd_ready_o high only in IDLE.
REQ-017 Quarter counter 0..QTR_DIV-1, tick at QTR_DIV-1, held at 0 in IDLE; each bit = 4 ticks q0..q3.
REQ-018 States IDLE, START, XFER, STOP; IDLE->START/XFER/STOP on accept; each returns to IDLE after its last q3 tick.
REQ-019 START: q0 release SDA and SCL; q1 SDA low; q2 SCL low; q3 end; valid as repeated start.
REQ-020 XFER bit: q0 SCL low, set SDA; q1 release SCL; q2 sample synchronized SDA; q3 SCL low.
REQ-021 WRITE: bits 1-8 drive wdata_i MSB first (1 = release); bit 9 release SDA, ack_o = ~sampled SDA.
REQ-022 READ: bits 1-8 release SDA, shift samples MSB first into rdata_o; bit 9 drive SDA low iff captured rd_ack_i = 1.
REQ-023 STOP: q0 SDA low; q1 release SCL; q2 release SDA; q3 end; bus left released.
REQ-024 Clock stretching: after q1 release, counter SHALL hold while synchronized SCL reads 0; q2 timing restarts when SCL reads 1.
REQ-025 rsp_valid_o pulses one cycle on entry to IDLE after every command; rdata_o updates only on READ, ack_o only on WRITE; both hold until next update.
REQ-026 Latency, no stretching: rsp_valid_o at cycle 4*QTR_DIV*N + 1 after accept, N = 1 START/STOP, N = 9 WRITE/READ.
REQ-027 busy_o high from accept edge until rsp_valid_o cycle inclusive; cmd_ready_o low over same span.
REQ-028 No protocol checking: WRITE/READ without prior START executes as specified; arbitration loss not detected.

Reset
REQ-029 rst_i low SHALL immediately release sda_bi and scl_bi ('z), clear rsp_valid_o, rdata_o, ack_o, busy_o, cmd_ready_o, counters and shift registers, state IDLE.
REQ-030 Reset mid-command aborts without rsp_valid_o; cmd_ready_o rises on first clock edge after rst_i returns high.

Verification (QTR_DIV = 4)
REQ-031 rst_i low during WRITE bit 4 -> both lines 'z same cycle, no rsp_valid_o; cmd_ready_o = 1 one edge after release.
REQ-032 START, then WRITE 0xA5 with ACKing slave model -> bits 1,0,1,0,0,1,0,1 at SCL rise, ack_o = 1, rsp_valid_o 145 cycles after accept.
REQ-033 WRITE 0x50, no slave (pull-up only) -> ack_o = 0, rsp_valid_o pulse, rdata_o unchanged.
REQ-034 READ, rd_ack_i = 0, slave sends 0x3C -> rdata_o = 0x3C, SDA released on bit 9, ack_o unchanged.
REQ-035 Slave holds SCL low 20 cycles after bit-3 release -> rsp_valid_o delayed by 20 to 22 cycles; SCL high time still 2*QTR_DIV.
REQ-036 STOP with cmd_valid_i held high throughout -> SDA rises while SCL high, no second accept until rsp_valid_o cycle, next command accepted the cycle after.
